// File: rtl/chess_clock.sv
// ----------------------------------------------------------------------------
// chess_clock -- two-player game clock with flag-fall detection.
//
// Counts down the remaining seconds of the side to move. A prescaler turns
// CLK_HZ cycles of play into one-second ticks. The clock pauses while the
// controller is loading. It stops for good on a checkmate code or when a side
// runs out of time. Only reset starts a new game.
//
// Optional feature (compile-time macro):
//   CHESS_CLOCK_INCREMENT_EN  -- when defined, the side that just moved gains
//                               INC_SECONDS on every turn change, saturating
//                               at 4095. When undefined, no increment logic is
//                               built.
//
// Parameters:
//   CLK_HZ         clock cycles per second of play (2 .. 2^27)
//   START_SECONDS  initial time per player (1 .. 4095)
//   INC_SECONDS    per-move increment (used only with the macro above)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   turn          in   side to move (0 = white, 1 = black)
//   loading       in   controller busy; pauses both clocks
//   checkmate     in   [1:0] game-over code; any nonzero value ends the game
//   timeout       out  [1:0] flag fall (bit0 white, bit1 black)
//   whiteSeconds  out  [11:0] white remaining seconds
//   blackSeconds  out  [11:0] black remaining seconds
//   running       out  clock is counting (RUN and not loading)
// ----------------------------------------------------------------------------
module chess_clock #(
   parameter int unsigned CLK_HZ        = 100000000,
   parameter int unsigned START_SECONDS = 600,
   parameter int unsigned INC_SECONDS   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        turn,
   input  logic        loading,
   input  logic [1:0]  checkmate,
   output logic [1:0]  timeout,
   output logic [11:0] whiteSeconds,
   output logic [11:0] blackSeconds,
   output logic        running
);

   localparam int unsigned SEC_W = 12;
   localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CLK_HZ - 1);
   localparam logic [SEC_W-1:0] START_VAL = SEC_W'(START_SECONDS);
   localparam logic [SEC_W-1:0] ONE_SEC   = SEC_W'(1);

   // Elaboration-time parameter legality check.
   if ((CLK_HZ < 2) || (CLK_HZ > (2**27)) || (START_SECONDS < 1) ||
       (START_SECONDS > 4095) || (INC_SECONDS > 4095)) begin : g_param_err
      $error("chess_clock: parameter out of legal range");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_FLAGGED = 2'd2,
      S_STOPPED = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [PRE_W-1:0]   r_presc;
   logic [SEC_W-1:0]   r_white;
   logic [SEC_W-1:0]   r_black;
   logic [1:0]         r_timeout;
   logic               r_running;
   logic               r_turn_q;

   logic [PRE_W-1:0]   w_presc_nxt;
   logic [SEC_W-1:0]   w_white_nxt;
   logic [SEC_W-1:0]   w_black_nxt;
   logic [1:0]         w_timeout_nxt;
   logic               w_running_nxt;

   logic               w_in_run;
   logic               w_turn_chg;
   logic               w_tick;
   logic               w_game_over;
   logic [SEC_W-1:0]   w_cur_secs;
   logic               w_flag;

   // Event decode: turn change beats a tick, checkmate beats everything.
   always_comb begin
      w_in_run    = (r_state == S_RUN);
      w_turn_chg  = (turn != r_turn_q);
      w_tick      = (r_presc == PRE_MAX) && !loading;
      w_game_over = |checkmate;
      w_cur_secs  = r_turn_q ? r_black : r_white;
      w_flag      = w_in_run && !w_game_over && !w_turn_chg && w_tick &&
                    (w_cur_secs == ONE_SEC);
   end

`ifdef CHESS_CLOCK_INCREMENT_EN
   localparam logic [SEC_W:0] INC_VAL = (SEC_W + 1)'(INC_SECONDS);

   logic [SEC_W:0]     w_inc_sum;
   logic [SEC_W-1:0]   w_inc_sat;

   // Bonus for the side that just moved, clamped to the 12-bit maximum.
   always_comb begin
      w_inc_sum = {1'b0, w_cur_secs} + INC_VAL;
      w_inc_sat = w_inc_sum[SEC_W] ? {SEC_W{1'b1}} : w_inc_sum[SEC_W-1:0];
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; FLAGGED and STOPPED are left only through reset.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (!loading) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_game_over) begin
               w_state_nxt = S_STOPPED;
            end else if (w_flag) begin
               w_state_nxt = S_FLAGGED;
            end
         end
         default: begin
            w_state_nxt = r_state;
         end
      endcase
   end

   // Output / datapath next values; everything holds outside RUN.
   always_comb begin
      w_presc_nxt   = r_presc;
      w_white_nxt   = r_white;
      w_black_nxt   = r_black;
      w_timeout_nxt = r_timeout;
      w_running_nxt = (w_state_nxt == S_RUN) && !loading;

      if (w_in_run && !w_game_over) begin
         if (w_turn_chg) begin
            // A move restarts the partial second for the new side.
            w_presc_nxt = '0;
`ifdef CHESS_CLOCK_INCREMENT_EN
            if (r_turn_q) begin
               w_black_nxt = w_inc_sat;
            end else begin
               w_white_nxt = w_inc_sat;
            end
`endif
         end else if (!loading) begin
            if (w_tick) begin
               w_presc_nxt = '0;
               if (w_cur_secs != '0) begin
                  if (r_turn_q) begin
                     w_black_nxt = r_black - ONE_SEC;
                  end else begin
                     w_white_nxt = r_white - ONE_SEC;
                  end
               end
               if (w_flag) begin
                  w_timeout_nxt = r_turn_q ? 2'b10 : 2'b01;
               end
            end else begin
               w_presc_nxt = r_presc + PRE_W'(1);
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc   <= '0;
         r_white   <= START_VAL;
         r_black   <= START_VAL;
         r_timeout <= 2'b00;
         r_running <= 1'b0;
         r_turn_q  <= 1'b0;
      end else begin
         r_presc   <= w_presc_nxt;
         r_white   <= w_white_nxt;
         r_black   <= w_black_nxt;
         r_timeout <= w_timeout_nxt;
         r_running <= w_running_nxt;
         r_turn_q  <= turn;
      end
   end

   assign timeout      = r_timeout;
   assign whiteSeconds = r_white;
   assign blackSeconds = r_black;
   assign running      = r_running;

endmodule

// File: tb/tb_chess_clock.sv
// ----------------------------------------------------------------------------
// tb_chess_clock -- self-checking bench for chess_clock (CLK_HZ=4,
// START_SECONDS=3). Directed vector tables, hand-written corner sequences and
// a randomized run against a game-level reference model.
// ----------------------------------------------------------------------------
module tb_chess_clock;

   localparam int CLK_HZ = 4;
   localparam int START  = 3;
   localparam int INC    = 5;
`ifdef CHESS_CLOCK_INCREMENT_EN
   localparam int INC_EFF = INC;
`else
   localparam int INC_EFF = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        turn = 1'b0;
   logic        loading = 1'b0;
   logic [1:0]  checkmate = 2'b00;
   logic [1:0]  timeout;
   logic [11:0] whiteSeconds;
   logic [11:0] blackSeconds;
   logic        running;

   chess_clock #(
      .CLK_HZ        (CLK_HZ),
      .START_SECONDS (START),
      .INC_SECONDS   (INC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .turn         (turn),
      .loading      (loading),
      .checkmate    (checkmate),
      .timeout      (timeout),
      .whiteSeconds (whiteSeconds),
      .blackSeconds (blackSeconds),
      .running      (running)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int ew, input int eb, input int et, input int er);
      check({tag, "_white"},   32'(whiteSeconds), 32'(ew));
      check({tag, "_black"},   32'(blackSeconds), 32'(eb));
      check({tag, "_timeout"}, 32'(timeout),      32'(et));
      check({tag, "_running"}, 32'(running),      32'(er));
   endtask

   // Drive inputs, then let one rising edge pass and settle.
   task automatic apply(input logic r, input logic t, input logic l, input logic [1:0] c);
      reset = r; turn = t; loading = l; checkmate = c;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       rst;
      logic       trn;
      logic       ld;
      logic [1:0] cm;
      int         ew;
      int         eb;
      int         et;
      int         er;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic r, input logic t, input logic l, input logic [1:0] c,
                          input int ew, input int eb, input int et, input int er);
      vec_t v;
      v.rst = r; v.trn = t; v.ld = l; v.cm = c;
      v.ew = ew; v.eb = eb; v.et = et; v.er = er;
      vecs.push_back(v);
   endtask

   // ---------------- reference model ----------------
   // Game-level view: has the game started / ended, seconds per side, and
   // how many running cycles the side to move has spent in the current second.
   int m_started, m_over, m_frac, m_prev, m_to, m_run;
   int m_secs[2];

   function automatic void m_reset();
      m_started = 0; m_over = 0; m_frac = 0; m_prev = 0; m_to = 0; m_run = 0;
      m_secs[0] = START; m_secs[1] = START;
   endfunction

   function automatic void m_step(input logic r, input logic t, input logic l, input logic [1:0] c);
      if (!r) begin
         m_reset();
         return;
      end
      if (m_started == 0) begin
         if (!l) m_started = 1;
      end else if (m_over == 0) begin
         if (c != 2'b00) begin
            m_over = 1;
         end else if (int'(t) != m_prev) begin
            m_frac = 0;
            m_secs[m_prev] = (m_secs[m_prev] + INC_EFF > 4095) ? 4095 : m_secs[m_prev] + INC_EFF;
         end else if (!l) begin
            m_frac++;
            if (m_frac == CLK_HZ) begin
               m_frac = 0;
               m_secs[m_prev]--;
               if (m_secs[m_prev] == 0) begin
                  m_to   = 1 << m_prev;
                  m_over = 1;
               end
            end
         end
      end
      m_run  = (m_started != 0 && m_over == 0 && !l) ? 1 : 0;
      m_prev = int'(t);
   endfunction

   logic       rnd_r;
   logic       rnd_t;
   logic       rnd_l;
   logic [1:0] rnd_c;
   int         over_cnt;

   initial begin
      // Segment A: plain countdown of white to flag fall.
      add_vec(0,0,0,2'b00, 3,3,0,0);
      add_vec(1,0,0,2'b00, 3,3,0,1);   // IDLE -> RUN
      add_vec(1,0,0,2'b00, 3,3,0,1);
      add_vec(1,0,0,2'b00, 3,3,0,1);
      add_vec(1,0,0,2'b00, 3,3,0,1);
      add_vec(1,0,0,2'b00, 2,3,0,1);   // first tick
      add_vec(1,0,0,2'b00, 2,3,0,1);
      add_vec(1,0,0,2'b00, 2,3,0,1);
      add_vec(1,0,0,2'b00, 2,3,0,1);
      add_vec(1,0,0,2'b00, 1,3,0,1);
      add_vec(1,0,0,2'b00, 1,3,0,1);
      add_vec(1,0,0,2'b00, 1,3,0,1);
      add_vec(1,0,0,2'b00, 1,3,0,1);
      add_vec(1,0,0,2'b00, 0,3,1,0);   // flag fall
      // Segment B: checkmate on the cycle white would go 1 -> 0.
      add_vec(0,0,0,2'b00, 3,3,0,0);
      add_vec(1,0,0,2'b00, 3,3,0,1);
      for (int k = 0; k < 3; k++) add_vec(1,0,0,2'b00, 3,3,0,1);
      for (int k = 0; k < 4; k++) add_vec(1,0,0,2'b00, 2,3,0,1);
      for (int k = 0; k < 4; k++) add_vec(1,0,0,2'b00, 1,3,0,1);
      add_vec(1,0,0,2'b10, 1,3,0,0);   // checkmate wins over the tick
      add_vec(1,1,0,2'b00, 1,3,0,0);
      add_vec(1,0,0,2'b00, 1,3,0,0);

      for (int i = 0; i < 14; i++) begin
         apply(vecs[i].rst, vecs[i].trn, vecs[i].ld, vecs[i].cm);
         check_outs($sformatf("vecA%0d", i), vecs[i].ew, vecs[i].eb, vecs[i].et, vecs[i].er);
      end

      // FLAGGED holds everything whatever the inputs do.
      for (int i = 0; i < 20; i++) begin
         apply(1'b1, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 2'($urandom_range(0,3)));
         check_outs($sformatf("frozen%0d", i), 0, 3, 1, 0);
      end

      // Asynchronous reset out of FLAGGED, observed before any clock edge.
      #2;
      reset = 1'b0;
      #1;
      check_outs("async_rst", 3, 3, 0, 0);

      for (int i = 14; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].trn, vecs[i].ld, vecs[i].cm);
         check_outs($sformatf("vecB%0d", i - 14), vecs[i].ew, vecs[i].eb, vecs[i].et, vecs[i].er);
      end

      // Loading pause in the middle of a second.
      apply(0,0,0,2'b00);
      apply(1,0,0,2'b00);
      apply(1,0,0,2'b00);
      apply(1,0,0,2'b00);
      for (int i = 0; i < 10; i++) begin
         apply(1,0,1,2'b00);
         check_outs($sformatf("load%0d", i), 3, 3, 0, 0);
      end
      apply(1,0,0,2'b00);
      check_outs("load_resume", 3, 3, 0, 1);
      apply(1,0,0,2'b00);
      check_outs("load_tick", 2, 3, 0, 1);

      // Turn change on the exact tick cycle.
      apply(0,0,0,2'b00);
      apply(1,0,0,2'b00);
      apply(1,0,0,2'b00);
      apply(1,0,0,2'b00);
      apply(1,0,0,2'b00);
      check_outs("pre_turn", 3, 3, 0, 1);
      apply(1,1,0,2'b00);
      check_outs("turn_on_tick", 3 + INC_EFF, 3, 0, 1);
      for (int i = 0; i < 3; i++) begin
         apply(1,1,0,2'b00);
         check_outs($sformatf("black_wait%0d", i), 3 + INC_EFF, 3, 0, 1);
      end
      apply(1,1,0,2'b00);
      check_outs("black_tick", 3 + INC_EFF, 2, 0, 1);

`ifdef CHESS_CLOCK_INCREMENT_EN
      // Alternate moves every cycle until both sides saturate.
      apply(0,0,0,2'b00);
      apply(1,0,0,2'b00);
      for (int k = 1; k <= 819; k++) begin
         apply(1,1,0,2'b00);
         apply(1,0,0,2'b00);
         if (k == 10)  check_outs("inc10", 53, 53, 0, 1);
         if (k == 818) check_outs("inc818", 4093, 4093, 0, 1);
      end
      check_outs("inc_sat", 4095, 4095, 0, 1);
`endif

      // Randomized play against the reference model.
      apply(0,0,0,2'b00);
      m_reset();
      rnd_t    = 1'b0;
      over_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         over_cnt = (m_over != 0) ? over_cnt + 1 : 0;
         rnd_r = !((over_cnt > 3) || ($urandom_range(0,149) == 0));
         if ($urandom_range(0,5) == 0) rnd_t = ~rnd_t;
         rnd_l = ($urandom_range(0,4) == 0);
         rnd_c = ($urandom_range(0,39) == 0) ? 2'($urandom_range(1,3)) : 2'b00;
         m_step(rnd_r, rnd_t, rnd_l, rnd_c);
         apply(rnd_r, rnd_t, rnd_l, rnd_c);
         check_outs($sformatf("rnd%0d", i), m_secs[0], m_secs[1], m_to, m_run);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
